// File: rtl/uart_pkg.sv
// Shared UART definitions: TX state encoding, 8N1 framing constants and the
// baud divisor helper used by both the transmit and receive paths.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    typedef enum logic {
        FRAME_IDLE = 1'b0,
        FRAME_SEND = 1'b1
    } frame_state_t;

    localparam int   UART_DATA_BITS        = 8;
    localparam int   UART_STOP_BITS        = 1;
    localparam logic UART_IDLE_LEVEL       = 1'b1;
    localparam int   UART_MIN_CLKS_PER_BIT = 4;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// Single-character 8N1 serialiser. A start accepted on the final stop-bit
// cycle chains straight into the next start bit, so characters abut.
module uart_byte_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       line,
    output logic       done
);

    localparam int               CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]       BIT_LAST = 3'(UART_DATA_BITS - 1);

    tx_state_t        state_reg, state_next;
    logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       data_reg, data_next;
    logic             bit_end;

    assign bit_end = (baud_cnt_reg == CNT_LAST);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_idx_reg  <= '0;
            data_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_idx_reg  <= bit_idx_next;
            data_reg     <= data_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        bit_idx_next  = bit_idx_reg;
        data_next     = data_reg;
        line          = UART_IDLE_LEVEL;
        done          = 1'b0;
        // The baud counter free-runs in every active state and wraps per bit.
        if (state_reg == IDLE || bit_end) begin
            baud_cnt_next = '0;
        end else begin
            baud_cnt_next = baud_cnt_reg + CNT_W'(1);
        end

        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = START;
                    data_next  = data;
                end
            end
            START: begin
                line = 1'b0;
                if (bit_end) begin
                    state_next   = DATA;
                    bit_idx_next = '0;
                end
            end
            DATA: begin
                line = data_reg[bit_idx_reg];
                if (bit_end) begin
                    if (bit_idx_reg == BIT_LAST) begin
                        state_next = STOP;
                    end else begin
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end
            end
            STOP: begin
                line = UART_IDLE_LEVEL;
                if (bit_end) begin
                    done = 1'b1;
                    if (start) begin
                        state_next = START;
                        data_next  = data;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_frame_tx.sv
// Frame transmitter: latches a BSN-byte response on request, sequences its
// bytes through the 8N1 serialiser and pulses uart_send_complete at the end.
module uart_frame_tx
    import uart_pkg::*;
#(
    parameter int BSN      = 4,
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200
) (
    input  logic           sys_clk,
    input  logic           rst,
    input  logic           uart_send_flag,
    input  logic [BSN*8-1:0] dataT,
    output logic           uart_txd,
    output logic           uart_busy,
    output logic           uart_send_complete
);

    localparam int               CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int               IDX_W        = (BSN > 1) ? $clog2(BSN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(BSN - 1);

    generate
        if (CLKS_PER_BIT < UART_MIN_CLKS_PER_BIT) begin : g_bad_baud
            $error("uart_frame_tx: CLK_FREQ/BAUD must be at least 4");
        end
        if (BSN < 1 || BSN > 16) begin : g_bad_bsn
            $error("uart_frame_tx: BSN must be in 1..16");
        end
    endgenerate

    frame_state_t     state_reg, state_next;
    logic [BSN*8-1:0] frame_reg, frame_next;
    logic [IDX_W-1:0] byte_idx_reg, byte_idx_next, byte_idx_inc;
    logic             complete_reg, complete_next;
    logic             txd_reg, busy_reg, send_complete_reg;
    logic [7:0]       frame_bytes [BSN];
    logic [7:0]       next_byte;
    logic [7:0]       byte_data;
    logic             byte_start, byte_done, byte_line;

    // Byte 0 is the most significant byte so string literals go out in order.
    genvar gi;
    generate
        for (gi = 0; gi < BSN; gi++) begin : g_bytes
            assign frame_bytes[gi] = frame_reg[(BSN-gi)*8-1 -: 8];
        end
    endgenerate

    assign byte_idx_inc = byte_idx_reg + IDX_W'(1);

    always_comb begin
        next_byte = '0;
        for (int i = 0; i < BSN; i++) begin
            if (IDX_W'(i) == byte_idx_inc) begin
                next_byte = frame_bytes[i];
            end
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_reg    <= FRAME_IDLE;
            frame_reg    <= '0;
            byte_idx_reg <= '0;
            complete_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            frame_reg    <= frame_next;
            byte_idx_reg <= byte_idx_next;
            complete_reg <= complete_next;
        end
    end

    // The first byte is taken straight from dataT so the start bit is not
    // delayed by the frame latch.
    always_comb begin
        state_next    = state_reg;
        frame_next    = frame_reg;
        byte_idx_next = byte_idx_reg;
        complete_next = 1'b0;
        byte_start    = 1'b0;
        byte_data     = next_byte;
        case (state_reg)
            FRAME_IDLE: begin
                if (uart_send_flag) begin
                    state_next    = FRAME_SEND;
                    frame_next    = dataT;
                    byte_idx_next = '0;
                    byte_start    = 1'b1;
                    byte_data     = dataT[BSN*8-1 -: 8];
                end
            end
            FRAME_SEND: begin
                if (byte_done) begin
                    if (byte_idx_reg < IDX_LAST) begin
                        byte_idx_next = byte_idx_inc;
                        byte_start    = 1'b1;
                    end else begin
                        state_next    = FRAME_IDLE;
                        complete_next = 1'b1;
                    end
                end
            end
            default: state_next = FRAME_IDLE;
        endcase
    end

    uart_byte_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_tx (
        .sys_clk(sys_clk),
        .rst    (rst),
        .start  (byte_start),
        .data   (byte_data),
        .line   (byte_line),
        .done   (byte_done)
    );

    // Output stage: every pin is registered, one cycle behind the sequencer.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            txd_reg           <= UART_IDLE_LEVEL;
            busy_reg          <= 1'b0;
            send_complete_reg <= 1'b0;
        end else begin
            txd_reg           <= byte_line;
            busy_reg          <= (state_reg != FRAME_IDLE);
            send_complete_reg <= complete_reg;
        end
    end

    assign uart_txd           = txd_reg;
    assign uart_busy          = busy_reg;
    assign uart_send_complete = send_complete_reg;

endmodule

// File: tb/tb_uart_frame_tx.sv
// Directed bench for uart_frame_tx at 16 clocks per bit, with a 4-byte and a
// 1-byte instance; line samples are logged per cycle and decoded mid-bit.
module tb_uart_frame_tx;

    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int CPB      = 16;
    localparam int CHAR_LEN = 10 * CPB;
    localparam int LOG_LEN  = 1400;

    logic        sys_clk = 1'b0;
    logic        rst;
    logic        uart_send_flag, uart_send_flag1;
    logic [31:0] dataT;
    logic [7:0]  dataT1;
    logic        uart_txd, uart_busy, uart_send_complete;
    logic        uart_txd1, uart_busy1, uart_send_complete1;

    int n_assert = 0;
    int n_fail   = 0;

    logic txd_log  [LOG_LEN];
    logic busy_log [LOG_LEN];
    logic cmp_log  [LOG_LEN];
    logic txd1_log [LOG_LEN];
    logic busy1_log[LOG_LEN];
    logic cmp1_log [LOG_LEN];

    always #5 sys_clk = ~sys_clk;

    uart_frame_tx #(.BSN(4), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .sys_clk           (sys_clk),
        .rst               (rst),
        .uart_send_flag    (uart_send_flag),
        .dataT             (dataT),
        .uart_txd          (uart_txd),
        .uart_busy         (uart_busy),
        .uart_send_complete(uart_send_complete)
    );

    uart_frame_tx #(.BSN(1), .CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut1 (
        .sys_clk           (sys_clk),
        .rst               (rst),
        .uart_send_flag    (uart_send_flag1),
        .dataT             (dataT1),
        .uart_txd          (uart_txd1),
        .uart_busy         (uart_busy1),
        .uart_send_complete(uart_send_complete1)
    );

    // Log index k holds the outputs just after edge k (edge 0 = acceptance).
    task automatic capture(input int n, input int hold_until, input int pulse_at,
                           input int change_at, input logic [31:0] new_data);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk);
            #1;
            txd_log[k]   = uart_txd;
            busy_log[k]  = uart_busy;
            cmp_log[k]   = uart_send_complete;
            txd1_log[k]  = uart_txd1;
            busy1_log[k] = uart_busy1;
            cmp1_log[k]  = uart_send_complete1;
            uart_send_flag  = (k + 1 < hold_until) || (k + 1 == pulse_at);
            uart_send_flag1 = 1'b0;
            if (k + 1 == change_at) dataT = new_data;
        end
    endtask

    function automatic logic [9:0] char_at(input int base);
        logic [9:0] c;
        for (int i = 0; i < 10; i++) c[i] = txd_log[base + CPB*i + CPB/2];
        return c;
    endfunction

    task automatic scan_complete(input int n, input bit single, output int cnt,
                                 output int first, output int second);
        cnt = 0; first = -1; second = -1;
        for (int k = 0; k < n; k++) begin
            logic p;
            p = single ? cmp1_log[k] : cmp_log[k];
            if (p === 1'b1) begin
                if (cnt == 0) first = k;
                else if (cnt == 1) second = k;
                cnt++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        uart_send_flag = 1'b0; uart_send_flag1 = 1'b0;
        dataT = '0; dataT1 = '0;
        repeat (3) @(posedge sys_clk);
        #1;
        n_assert++;
        if ({uart_txd, uart_busy, uart_send_complete} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_values: txd/busy/cmp=%b required 100", {uart_txd, uart_busy, uart_send_complete});
        end
        rst = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge sys_clk);
            #1;
            n_assert++;
            if ({uart_txd, uart_busy, uart_send_complete, uart_txd1, uart_busy1, uart_send_complete1} !== 6'b100100) begin
                n_fail++;
                $display("FAIL idle_cycle_%0d: outputs=%b required 100100", k,
                         {uart_txd, uart_busy, uart_send_complete, uart_txd1, uart_busy1, uart_send_complete1});
            end
        end
    endtask

    task automatic test_basic_frame();
        logic [31:0] exp;
        logic [7:0]  b;
        logic [9:0]  c;
        int cnt, first, second;
        exp = "DEFG";
        dataT = exp; uart_send_flag = 1'b1;
        capture(700, 1, 0, 0, '0);
        for (int k = 0; k < 4; k++) begin
            b = exp[31 - 8*k -: 8];
            c = char_at(1 + CHAR_LEN*k);
            n_assert++;
            if (c !== {1'b1, b, 1'b0}) begin
                n_fail++;
                $display("FAIL basic_char%0d: line=%b required %b", k, c, {1'b1, b, 1'b0});
            end
        end
        scan_complete(700, 1'b0, cnt, first, second);
        n_assert++;
        if (cnt != 1 || first != 641) begin
            n_fail++;
            $display("FAIL basic_complete: count=%0d at=%0d required 1 at 641", cnt, first);
        end
        n_assert++;
        if ({txd_log[0], txd_log[1], txd_log[641]} !== 3'b101) begin
            n_fail++;
            $display("FAIL basic_txd_edges: txd@0,1,641=%b required 101", {txd_log[0], txd_log[1], txd_log[641]});
        end
        n_assert++;
        if ({busy_log[0], busy_log[1], busy_log[640], busy_log[641]} !== 4'b0110) begin
            n_fail++;
            $display("FAIL basic_busy: busy@0,1,640,641=%b required 0110",
                     {busy_log[0], busy_log[1], busy_log[640], busy_log[641]});
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] exp;
        logic [7:0]  b;
        logic [9:0]  c;
        int cnt, first, second, late;
        exp = "WXYZ";
        dataT = exp; uart_send_flag = 1'b1;
        capture(1400, 1, 200, 50, "abcd");
        for (int k = 0; k < 4; k++) begin
            b = exp[31 - 8*k -: 8];
            c = char_at(1 + CHAR_LEN*k);
            n_assert++;
            if (c !== {1'b1, b, 1'b0}) begin
                n_fail++;
                $display("FAIL busy_char%0d: line=%b required %b", k, c, {1'b1, b, 1'b0});
            end
        end
        scan_complete(1400, 1'b0, cnt, first, second);
        n_assert++;
        if (cnt != 1 || first != 641) begin
            n_fail++;
            $display("FAIL busy_complete: count=%0d at=%0d required 1 at 641", cnt, first);
        end
        late = 0;
        for (int k = 641; k < 1400; k++) if (busy_log[k] !== 1'b0 || txd_log[k] !== 1'b1) late++;
        n_assert++;
        if (late != 0) begin
            n_fail++;
            $display("FAIL busy_no_extra_frame: active cycles after 641=%0d required 0", late);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] exp;
        logic [7:0]  b;
        logic [9:0]  c;
        int cnt, first, second, bad;
        dataT = "DEFG"; uart_send_flag = 1'b1;
        capture(250, 1, 0, 0, '0);
        #2 rst = 1'b1;
        #1;
        n_assert++;
        if ({uart_txd, uart_busy, uart_send_complete} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_mid_async: txd/busy/cmp=%b required 100", {uart_txd, uart_busy, uart_send_complete});
        end
        repeat (2) @(posedge sys_clk);
        #1 rst = 1'b0;
        capture(700, 1, 0, 0, '0);
        scan_complete(700, 1'b0, cnt, first, second);
        bad = 0;
        for (int k = 0; k < 700; k++) if (txd_log[k] !== 1'b1) bad++;
        n_assert++;
        if (cnt != 0 || bad != 0) begin
            n_fail++;
            $display("FAIL reset_mid_aborted: complete=%0d low_cycles=%0d required 0 0", cnt, bad);
        end
        exp = "1234";
        dataT = exp; uart_send_flag = 1'b1;
        capture(700, 1, 0, 0, '0);
        for (int k = 0; k < 4; k++) begin
            b = exp[31 - 8*k -: 8];
            c = char_at(1 + CHAR_LEN*k);
            n_assert++;
            if (c !== {1'b1, b, 1'b0}) begin
                n_fail++;
                $display("FAIL reset_mid_char%0d: line=%b required %b", k, c, {1'b1, b, 1'b0});
            end
        end
        scan_complete(700, 1'b0, cnt, first, second);
        n_assert++;
        if (cnt != 1 || first != 641) begin
            n_fail++;
            $display("FAIL reset_mid_complete: count=%0d at=%0d required 1 at 641", cnt, first);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        logic [7:0]  b;
        logic [9:0]  c;
        int cnt, first, second;
        exp = "PQRS";
        dataT = exp; uart_send_flag = 1'b1;
        capture(1400, 700, 0, 0, '0);
        scan_complete(1400, 1'b0, cnt, first, second);
        n_assert++;
        if (cnt != 2 || first != 641 || second != 1282) begin
            n_fail++;
            $display("FAIL b2b_complete: count=%0d at=%0d,%0d required 2 at 641,1282", cnt, first, second);
        end
        n_assert++;
        if ({txd_log[641], txd_log[642], busy_log[642], busy_log[1283]} !== 4'b1010) begin
            n_fail++;
            $display("FAIL b2b_restart: txd@641,642 busy@642,1283=%b required 1010",
                     {txd_log[641], txd_log[642], busy_log[642], busy_log[1283]});
        end
        for (int k = 0; k < 4; k++) begin
            b = exp[31 - 8*k -: 8];
            c = char_at(642 + CHAR_LEN*k);
            n_assert++;
            if (c !== {1'b1, b, 1'b0}) begin
                n_fail++;
                $display("FAIL b2b_second_char%0d: line=%b required %b", k, c, {1'b1, b, 1'b0});
            end
        end
    endtask

    task automatic test_single_byte();
        logic [9:0] exp_bits;
        int cnt, first, second;
        exp_bits = 10'b1101001010;
        dataT1 = 8'hA5; uart_send_flag1 = 1'b1;
        capture(200, 1, 0, 0, '0);
        for (int i = 0; i < 10; i++) begin
            n_assert++;
            if (txd1_log[1 + CPB*i + CPB/2] !== exp_bits[i]) begin
                n_fail++;
                $display("FAIL single_bit%0d: line=%b required %b", i, txd1_log[1 + CPB*i + CPB/2], exp_bits[i]);
            end
        end
        scan_complete(200, 1'b1, cnt, first, second);
        n_assert++;
        if (cnt != 1 || first != 161) begin
            n_fail++;
            $display("FAIL single_complete: count=%0d at=%0d required 1 at 161", cnt, first);
        end
        n_assert++;
        if ({busy1_log[1], busy1_log[160], busy1_log[161], txd1_log[161]} !== 4'b1101) begin
            n_fail++;
            $display("FAIL single_busy: busy@1,160,161 txd@161=%b required 1101",
                     {busy1_log[1], busy1_log[160], busy1_log[161], txd1_log[161]});
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_single_byte();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
